// File: rtl/div_share_arb_pkg.sv
// Shared constants for the divider-sharing arbiter: FSM encoding, default widths, pointer helper.
package div_share_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int DEF_W  = 400;
  localparam int DEF_DW = 8;

  function automatic int wrap_add(input int a, input int b, input int n);
    return (a + b) % n;
  endfunction

endpackage

// File: rtl/div_share_arb_rr_picker.sv
// Round-robin picker: first valid at or above ptr, wrapping; purely combinational.
// Zero latency; no backpressure of its own (grant is all-zero when nothing is valid).
module rr_picker
  import div_share_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         valid,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx
);
  localparam int IW = $clog2(N);

  logic [IW-1:0] pos;
  logic          found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      pos = IW'(wrap_add(int'(ptr), k, N));
      if (!found && valid[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end

endmodule

// File: rtl/div_share_arb.sv
// Shares one divider among N_REQ requesters; grant->div_start 1 cycle, div_done->resp_valid 1 cycle.
// Backpressure: response held until resp_ready of the granted requester; no grants while busy.
module div_share_arb
  import div_share_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int W       = DEF_W,
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*W-1:0]  req_dividend,
  input  logic [N_REQ*DW-1:0] req_divisor,
  output logic [N_REQ-1:0]    resp_valid,
  input  logic [N_REQ-1:0]    resp_ready,
  output logic [W-1:0]        resp_quotient,
  output logic                resp_err,
  output logic                busy,
  output logic                div_start,
  output logic [W-1:0]        div_dividend,
  output logic [DW-1:0]       div_divisor,
  input  logic [W-1:0]        div_quotient,
  input  logic                div_done
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [IW-1:0]    rr_ptr, g, pick_idx;
  logic [N_REQ-1:0] pick_grant;
  logic [CW-1:0]    cnt;
  logic [W-1:0]     sel_dividend;
  logic [DW-1:0]    sel_divisor;
  logic             grant_any, cnt_last;

  rr_picker #(.N(N_REQ)) u_rr_picker (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  always_comb begin
    sel_dividend = '0;
    sel_divisor  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == IW'(i)) begin
        sel_dividend = req_dividend[i*W +: W];
        sel_divisor  = req_divisor[i*DW +: DW];
      end
    end
  end

  assign grant_any = |pick_grant;
  assign cnt_last  = (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    resp_valid = '0;
    div_start  = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        // Gate the combinational grant so every output reads zero while rst is held.
        if (!rst) req_ready = pick_grant;
        if (grant_any) state_nxt = (sel_divisor == '0) ? RESP : ISSUE;
      end
      ISSUE: begin
        div_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (div_done || cnt_last) state_nxt = RESP;
      end
      RESP: begin
        resp_valid[g] = 1'b1;
        if (resp_ready[g]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr        <= '0;
      g             <= '0;
      cnt           <= '0;
      div_dividend  <= '0;
      div_divisor   <= '0;
      resp_quotient <= '0;
      resp_err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            g            <= pick_idx;
            div_dividend <= sel_dividend;
            div_divisor  <= sel_divisor;
            if (sel_divisor == '0) begin
              resp_quotient <= '1;
              resp_err      <= 1'b1;
            end
          end
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          cnt <= cnt + 1'b1;
          // A completion on the final counted cycle still wins over the abort.
          if (div_done) begin
            resp_quotient <= div_quotient;
            resp_err      <= 1'b0;
          end else if (cnt_last) begin
            resp_quotient <= '0;
            resp_err      <= 1'b1;
          end
        end
        RESP: begin
          if (resp_ready[g]) rr_ptr <= IW'(wrap_add(int'(g), 1, N_REQ));
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_share_arb.sv
// Randomized bench for div_share_arb with a stub divider and a transaction-level reference model.
module tb_div_share_arb;
  import div_share_arb_pkg::*;

  localparam int N   = 4;
  localparam int W   = DEF_W;
  localparam int DW  = DEF_DW;
  localparam int TMO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready, resp_valid, resp_ready;
  logic [N*W-1:0]  req_dividend;
  logic [N*DW-1:0] req_divisor;
  logic [W-1:0]    resp_quotient, div_dividend, div_quotient;
  logic            resp_err, busy, div_start, div_done;
  logic [DW-1:0]   div_divisor;

  always #5 clk = ~clk;

  div_share_arb #(.N_REQ(N), .W(W), .DW(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_quotient(resp_quotient), .resp_err(resp_err), .busy(busy),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_done(div_done)
  );

  int n_cmp, n_bad;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Stub divider: random latency, optional hang, plus an injectable stray done.
  logic         stub_done, inject, inj_req, hang;
  logic [W-1:0] stub_q, op_q, inj_q;
  int           stub_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stub_done <= 1'b0;
      stub_q    <= '0;
      op_q      <= '0;
      stub_cnt  <= 0;
    end else begin
      stub_done <= 1'b0;
      if (div_start) begin
        stub_cnt <= $urandom_range(1, 8);
        op_q     <= (div_divisor == '0) ? '1 : div_dividend / div_divisor;
      end else if (stub_cnt != 0) begin
        stub_cnt <= stub_cnt - 1;
        if (stub_cnt == 1 && !hang) begin
          stub_done <= 1'b1;
          stub_q    <= op_q;
        end
      end
    end
  end

  assign div_done     = stub_done | inject;
  assign div_quotient = inject ? inj_q : stub_q;

  // Requester-side stimulus state.
  logic [W-1:0]  dvd[N];
  logic [DW-1:0] dvs[N];
  logic [DW-1:0] fair_div[N];
  logic [N-1:0]  pending, keep;
  bit            rand_on;
  int            rr_mode, cyc;

  // Reference model of the single in-flight transaction.
  bit           act, m_zero, m_err, last_err;
  int           m_ptr, m_g, m_T, m_S, m_due, obs_start, obs_rv, n_start, done_cnt;
  logic [W-1:0] m_q, m_dvd, last_q;
  logic [DW-1:0] m_dvs;
  int           grant_log[$], hs_log[$], acc_log[$];

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] r = '0;
    for (int k = 0; k < W; k += 32) r = (r << 32) | W'($urandom);
    return r >> $urandom_range(0, W - 1);
  endfunction

  function automatic int model_pick(input logic [N-1:0] v, input int p);
    int best = -1;
    int bd   = N;
    for (int i = 0; i < N; i++)
      if (v[i] && ((i - p + N) % N) < bd) begin
        bd   = (i - p + N) % N;
        best = i;
      end
    return best;
  endfunction

  task automatic model_reset();
    act = 0; m_ptr = 0; m_S = -1; m_due = -1; obs_start = -1; obs_rv = -1;
  endtask

  task automatic apply_inputs();
    inject  = inj_req;
    inj_req = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!pending[i] && keep[i]) begin
        pending[i] = 1'b1; dvd[i] = rand_w(); dvs[i] = fair_div[i];
      end else if (!pending[i] && rand_on && $urandom_range(0, 5) == 0) begin
        pending[i] = 1'b1; dvd[i] = rand_w();
        dvs[i] = ($urandom_range(0, 9) == 0) ? '0 : DW'($urandom_range(1, 255));
      end
      req_valid[i]             = pending[i];
      req_dividend[i*W +: W]   = dvd[i];
      req_divisor[i*DW +: DW]  = dvs[i];
    end
    case (rr_mode)
      0:       resp_ready = '1;
      1:       resp_ready = N'($urandom);
      default: resp_ready = '0;
    endcase
  endtask

  task automatic monitor();
    bit           a;
    bit           exp_st;
    int           gi;
    logic [N-1:0] exp_rv, exp_gnt;
    a = act;
    chk("busy", busy, a);
    if (a && m_S >= 0 && m_due < 0 && cyc > m_S) begin
      if (div_done) m_due = cyc + 1;
      else if (cyc == m_S + TMO) begin
        m_due = cyc + 1; m_q = '0; m_err = 1;
      end
    end
    exp_st = a && !m_zero && (cyc == m_T + 1);
    chk("div_start", div_start, exp_st);
    if (div_start) begin n_start++; obs_start = cyc; end
    if (exp_st) begin
      m_S = cyc;
      chk("div_dividend", div_dividend, m_dvd);
      chk("div_divisor", div_divisor, m_dvs);
    end
    exp_rv = '0;
    if (a && m_due >= 0 && cyc >= m_due) exp_rv[m_g] = 1'b1;
    chk("resp_valid", resp_valid, exp_rv);
    if (resp_valid != '0 && obs_rv < 0) obs_rv = cyc;
    if (exp_rv != '0) begin
      chk("resp_quotient", resp_quotient, m_q);
      chk("resp_err", resp_err, m_err);
      if (resp_ready[m_g]) begin
        act = 0; m_ptr = (m_g + 1) % N;
        last_q = resp_quotient; last_err = resp_err; done_cnt++;
        acc_log.push_back(cyc);
      end
    end
    gi = a ? -1 : model_pick(req_valid, m_ptr);
    exp_gnt = '0;
    if (gi >= 0) exp_gnt[gi] = 1'b1;
    chk("req_ready", req_ready, exp_gnt);
    if ((req_valid & req_ready) != '0) hs_log.push_back(cyc);
    if (gi >= 0) begin
      act = 1; m_g = gi; m_T = cyc; m_dvd = dvd[gi]; m_dvs = dvs[gi];
      m_zero = (dvs[gi] == '0); m_err = m_zero;
      m_q = m_zero ? '1 : dvd[gi] / dvs[gi];
      m_S = -1; m_due = m_zero ? cyc + 1 : -1; obs_start = -1; obs_rv = -1;
      pending[gi] = 1'b0;
      grant_log.push_back(gi);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    apply_inputs();
    #1;
    if (!rst) monitor();
  endtask

  task automatic issue(input int i, input logic [W-1:0] a, input logic [DW-1:0] b);
    dvd[i] = a; dvs[i] = b; pending[i] = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((act || pending != '0) && k < budget) begin tick(); k++; end
    chk("wait_idle", (act || pending != '0), 0);
  endtask

  task automatic wait_rv(input int budget);
    int k = 0;
    while (resp_valid == '0 && k < budget) begin tick(); k++; end
    chk("wait_rv", resp_valid != '0, 1);
  endtask

  task automatic check_zero(input string p);
    chk({p, "_req_ready"}, req_ready, '0);
    chk({p, "_resp_valid"}, resp_valid, '0);
    chk({p, "_resp_quotient"}, resp_quotient, '0);
    chk({p, "_resp_err"}, resp_err, '0);
    chk({p, "_busy"}, busy, '0);
    chk({p, "_div_start"}, div_start, '0);
    chk({p, "_div_dividend"}, div_dividend, '0);
    chk({p, "_div_divisor"}, div_divisor, '0);
  endtask

  initial begin
    logic [W-1:0] one_w, ones_w;
    int           exp_order[5];
    int           k, ns, hold_cnt, dc;
    one_w  = 1;
    ones_w = '1;
    exp_order = '{0, 1, 2, 3, 0};
    n_cmp = 0; n_bad = 0; cyc = 0; n_start = 0; done_cnt = 0;
    rr_mode = 0; rand_on = 0; keep = '0; pending = '0;
    hang = 0; inject = 0; inj_req = 0; inj_q = '0;
    req_valid = '0; resp_ready = '0; req_dividend = '0; req_divisor = '0;
    last_q = '0; last_err = 0;
    for (int i = 0; i < N; i++) begin dvd[i] = '0; dvs[i] = '0; end
    model_reset();
    rst = 1'b1;
    #3;
    check_zero("rst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Fairness: everyone always requesting.
    fair_div = '{8'd3, 8'd5, 8'd7, 8'd9};
    grant_log.delete();
    keep = '1;
    k = 0;
    while (grant_log.size() < 5 && k < 200) begin tick(); k++; end
    keep = '0;
    chk("fair_bound", grant_log.size() >= 5, 1);
    for (int i = 0; i < 5 && i < grant_log.size(); i++) chk("fair_order", grant_log[i], exp_order[i]);
    wait_idle(300);

    // Single request from requester 1.
    issue(1, one_w << 396, 8'd2);
    wait_idle(100);
    chk("single_g", grant_log[$], 1);
    chk("single_start_lat", obs_start - m_T, 1);
    chk("single_q", last_q, one_w << 395);
    chk("single_err", last_err, 0);

    // Zero divisor from requester 2.
    ns = n_start;
    issue(2, rand_w(), 8'd0);
    wait_idle(100);
    chk("zero_nostart", n_start - ns, 0);
    chk("zero_lat", obs_rv - m_T, 1);
    chk("zero_q", last_q, ones_w);
    chk("zero_err", last_err, 1);

    // Timeout with a stray done while the response is held.
    hang = 1; rr_mode = 2;
    issue(0, rand_w(), 8'd5);
    wait_rv(60);
    inj_q = rand_w(); inj_req = 1'b1;
    repeat (4) tick();
    rr_mode = 0;
    wait_idle(20);
    hang = 0;
    chk("tmo_lat", obs_rv - obs_start, TMO + 1);
    chk("tmo_q", last_q, '0);
    chk("tmo_err", last_err, 1);

    // Backpressure with other requesters waiting.
    rr_mode = 2;
    issue(3, rand_w(), DW'($urandom_range(1, 255)));
    k = 0;
    while (!act && k < 10) begin tick(); k++; end
    issue(0, rand_w(), DW'($urandom_range(1, 255)));
    issue(1, rand_w(), DW'($urandom_range(1, 255)));
    wait_rv(30);
    hold_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (resp_valid == 4'b1000) hold_cnt++;
    end
    chk("bp_held", hold_cnt, 10);
    hs_log.delete(); acc_log.delete();
    rr_mode = 0;
    wait_idle(100);
    chk("bp_resume", hs_log[0] - acc_log[0], 1);

    // Random traffic.
    rand_on = 1; rr_mode = 1;
    repeat (400) tick();
    rand_on = 0; rr_mode = 0;
    wait_idle(400);

    // Reset during WAIT with rr_ptr parked at 3.
    issue(2, rand_w(), 8'd7);
    wait_idle(60);
    hang = 1;
    issue(3, rand_w(), 8'd3);
    k = 0;
    while (obs_start < 0 && k < 20) begin tick(); k++; end
    chk("mid_started", obs_start >= 0, 1);
    repeat (2) tick();
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check_zero("mid_rst");
    model_reset();
    pending = '0; req_valid = '0; hang = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    grant_log.delete();
    dc = done_cnt;
    issue(1, rand_w(), DW'($urandom_range(1, 255)));
    issue(3, rand_w(), DW'($urandom_range(1, 255)));
    wait_idle(100);
    chk("post_rst_grant", grant_log[0], 1);
    chk("post_rst_done", done_cnt - dc, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/div_share_arb.md
# div_share_arb

Round-robin arbiter that shares one `divider_400bit` instance between up to `N_REQ` requesters, such as several series-term generators in the constant-calculation designs. It sits between the requesters and the divider's start/done port. It accepts one division request at a time and sequences the divider's start pulse and operands. It returns the quotient to the granted requester with a valid/ready response handshake. Zero divisors and divider hangs are reported through an error flag instead of stalling the shared resource.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `W`, 400: dividend/quotient width, fixed-point with 4 integer bits.
- `DW`, 8: divisor width.
- `TIMEOUT`, 1024: maximum cycles from `div_start` to `div_done` before abort.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  N_REQ  per-requester request valid.
- `req_ready`  out  N_REQ  one-hot grant/accept.
- `req_dividend`  in  N_REQ*W  flattened; requester i in bits [i*W +: W].
- `req_divisor`  in  N_REQ*DW  flattened; requester i in bits [i*DW +: DW].
- `resp_valid`  out  N_REQ  one-hot response valid.
- `resp_ready`  in  N_REQ  per-requester response accept.
- `resp_quotient`  out  W  shared response data.
- `resp_err`  out  1  response is an error (zero divisor or timeout).
- `busy`  out  1  high in any state other than IDLE.
- `div_start`  out  1  one-cycle start pulse to the divider.
- `div_dividend`  out  W  divider operand.
- `div_divisor`  out  DW  divider operand.
- `div_quotient`  in  W  divider result.
- `div_done`  in  1  divider completion; `div_quotient` is valid in the same cycle.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- Reset values:
  - all outputs 0;
  - round-robin pointer `rr_ptr` = 0;
  - state IDLE.
- IDLE:
  - `req_ready` is combinational: a one-hot grant to the first i with `req_valid[i]`, searching from `rr_ptr` upward and wrapping at N_REQ-1 → 0. It is all-zero if no request is valid.
  - On handshake, register dividend, divisor and grant index `g`.
  - If divisor == 0, go to RESP with `resp_quotient` = all-ones and `resp_err` = 1.
  - Otherwise go to ISSUE.
- ISSUE:
  - `div_start` = 1 for exactly this cycle.
  - `div_dividend`/`div_divisor` are driven from the captured registers and held stable until leaving WAIT.
  - Clear the timeout counter; go to WAIT.
- WAIT:
  - Count cycles.
  - On `div_done`, latch `div_quotient` into `resp_quotient`, set `resp_err` = 0, go to RESP.
  - If the counter reaches TIMEOUT-1 without `div_done`, set `resp_quotient` = 0 and `resp_err` = 1, then go to RESP.
- RESP:
  - `resp_valid[g]` = 1; hold `resp_quotient` and `resp_err` stable until `resp_ready[g]`.
  - On acceptance, set `rr_ptr` = (g+1) mod N_REQ and go to IDLE.
  - `resp_ready` bits other than g are ignored.
- Requester rules: `req_valid` must stay high, with stable operands, until `req_ready`. Other requesters' `req_valid` may change freely while the arbiter is busy.
- `div_done` in IDLE, ISSUE or RESP is ignored. A late `div_done` after a timeout must not corrupt a held response.
- `rst` mid-operation returns the block to IDLE immediately and drops any in-flight request. The divider shares the same `rst`.

## Timing
- Request handshake at cycle T → `div_start` at T+1.
- `div_done` at cycle D → `resp_valid` high from D+1.
- With `resp_ready` held high, the next grant is possible at D+2.
- Zero divisor: handshake at T → `resp_valid` at T+1; the divider is never started.
- Timeout: `div_start` at S with no `div_done` → `resp_valid` with `resp_err` at S+TIMEOUT+1.
- No back-to-back overlap: at most one division is in flight.
- Throughput is 1 per (divider latency + 3) cycles.

## Structure
- Shared constants go in a shared parameters header: state encodings (IDLE=0, ISSUE=1, WAIT=2, RESP=3), default W and DW. The same W/DW constants are reused by the divider and adder.
- One sub-module, `rr_picker`: N_REQ-bit valid vector plus `rr_ptr` in, one-hot grant and binary index out, combinational.
- Timeout counter width is clog2(TIMEOUT).

## Test plan
- Single request: requester 1 sends dividend 1<<396, divisor 2.
  - Expect `div_start` one cycle after the handshake.
  - Expect `resp_valid` = 4'b0010 with quotient 1<<395 and `resp_err` = 0.
- Fairness: all four requesters assert continuously with divisors 3, 5, 7, 9.
  - Expect grant order 0,1,2,3,0.
  - Each quotient matches floor(dividend/divisor).
  - No requester is granted twice before the others are served.
- Zero divisor: requester 2 sends divisor 0.
  - Expect `resp_valid[2]` at T+1 with quotient all-ones and `resp_err` = 1.
  - `div_start` never pulses.
- Timeout: stub divider never raises done; TIMEOUT = 16.
  - Expect `resp_err` = 1 and quotient 0 at S+17.
  - A stray `div_done` injected during RESP leaves the held quotient unchanged.
- Backpressure: hold `resp_ready` low for 10 cycles.
  - `resp_valid`/`resp_quotient` stay stable.
  - Other requesters' `req_ready` stays 0.
  - Grant resumes the cycle after acceptance.
- Reset mid-WAIT: assert `rst` during WAIT.
  - All outputs clear asynchronously; state is IDLE and `rr_ptr` = 0.
  - A fresh request completes normally afterwards.
